// File: rtl/pipe_io_timer_pkg.sv
// Shared register map and bit positions for the memory-mapped countdown timer.
package pipe_io_timer_pkg;

    localparam int unsigned TMR_DATA_W    = 32;
    localparam int unsigned TMR_OFF_W     = 3;
    localparam int unsigned TMR_EXPCNT_W  = 8;

    localparam logic [TMR_OFF_W-1:0] TMR_CTRL   = 3'd0;
    localparam logic [TMR_OFF_W-1:0] TMR_LOAD   = 3'd1;
    localparam logic [TMR_OFF_W-1:0] TMR_COUNT  = 3'd2;
    localparam logic [TMR_OFF_W-1:0] TMR_STATUS = 3'd3;
    localparam logic [TMR_OFF_W-1:0] TMR_PRESC  = 3'd4;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_RELOAD_BIT  = 1;
    localparam int unsigned STAT_EXPIRED_BIT = 0;
    localparam int unsigned STAT_EXPCNT_LSB  = 8;

endpackage

// File: rtl/tmr_prescaler.sv
// Prescaler: counts 0..PRESC while enabled and pulses a tick on the terminal count.
module tmr_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick_c
);

    logic [PRESC_W-1:0] r_pcnt;
    logic               w_hit;

    assign w_hit    = (r_pcnt == i_presc);
    // A synchronous clear restarts the period, so no tick leaks out on that edge.
    assign o_tick_c = i_en & w_hit & ~i_clr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pcnt <= '0;
        end else if (i_clr) begin
            r_pcnt <= '0;
        end else if (i_en) begin
            r_pcnt <= w_hit ? '0 : r_pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pipe_io_timer.sv
// Countdown timer peripheral on the MEM-stage data bus: window decode, registers, countdown.
module pipe_io_timer
    import pipe_io_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_00c0,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic        sel,
    output logic [31:0] dataout,
    output logic        tick_out
);

    logic                    r_en;
    logic                    r_reload;
    logic [TMR_DATA_W-1:0]   r_load;
    logic [TMR_DATA_W-1:0]   r_count;
    logic                    r_expired;
    logic [TMR_EXPCNT_W-1:0] r_exp_cnt;
    logic [PRESC_W-1:0]      r_presc;
    logic                    r_tick_out;

    logic [TMR_OFF_W-1:0]    w_off;
    logic                    w_wr;
    logic                    w_ctrl_wr;
    logic                    w_load_wr;
    logic                    w_stat_wr;
    logic                    w_presc_wr;
    logic                    w_tick;
    logic                    w_step;
    logic                    w_expire;
    logic [TMR_DATA_W-1:0]   w_rdata;
    logic                    w_unused_byte_sel;

    assign sel               = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_off             = addr[4:2];
    assign w_unused_byte_sel = ^addr[1:0];
    assign w_wr              = wmem & sel;
    assign w_ctrl_wr         = w_wr & (w_off == TMR_CTRL);
    assign w_load_wr         = w_wr & (w_off == TMR_LOAD);
    assign w_stat_wr         = w_wr & (w_off == TMR_STATUS);
    assign w_presc_wr        = w_wr & (w_off == TMR_PRESC);

    tmr_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clock    (clock),
        .resetn   (resetn),
        .i_en     (r_en),
        .i_clr    (w_ctrl_wr & datain[CTRL_EN_BIT]),
        .i_presc  (r_presc),
        .o_tick_c (w_tick)
    );

    // Any CTRL or LOAD store on this edge takes priority over the countdown.
    assign w_step   = w_tick & ~w_ctrl_wr & ~w_load_wr;
    assign w_expire = w_step & (r_count == TMR_DATA_W'(1));

    always_comb begin
        w_rdata = '0;
        case (w_off)
            TMR_CTRL: begin
                w_rdata[CTRL_EN_BIT]     = r_en;
                w_rdata[CTRL_RELOAD_BIT] = r_reload;
            end
            TMR_LOAD:  w_rdata = r_load;
            TMR_COUNT: w_rdata = r_count;
            TMR_STATUS: begin
                w_rdata[STAT_EXPIRED_BIT] = r_expired;
                w_rdata[STAT_EXPCNT_LSB +: TMR_EXPCNT_W] = r_exp_cnt;
            end
            TMR_PRESC: w_rdata = TMR_DATA_W'(r_presc);
            default:   w_rdata = '0;
        endcase
    end

    assign dataout  = sel ? w_rdata : '0;
    assign tick_out = r_tick_out;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_en       <= 1'b0;
            r_reload   <= 1'b0;
            r_load     <= '0;
            r_count    <= '0;
            r_expired  <= 1'b0;
            r_exp_cnt  <= '0;
            r_presc    <= '0;
            r_tick_out <= 1'b0;
        end else begin
            r_tick_out <= w_expire;

            if (w_ctrl_wr) begin
                r_en     <= datain[CTRL_EN_BIT];
                r_reload <= datain[CTRL_RELOAD_BIT];
            end else if (w_expire && !r_reload) begin
                r_en <= 1'b0;
            end

            if (w_load_wr) begin
                r_load  <= datain;
                r_count <= datain;
            end else if (w_expire) begin
                r_count <= r_reload ? r_load : '0;
            end else if (w_step && (r_count != '0)) begin
                r_count <= r_count - TMR_DATA_W'(1);
            end

            // Expiry set beats a same-edge write-1-to-clear.
            if (w_expire) begin
                r_expired <= 1'b1;
                r_exp_cnt <= r_exp_cnt + TMR_EXPCNT_W'(1);
            end else if (w_stat_wr && datain[STAT_EXPIRED_BIT]) begin
                r_expired <= 1'b0;
            end

            if (w_presc_wr) begin
                r_presc <= datain[PRESC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pipe_io_timer.sv
// Directed bench for pipe_io_timer: expected values queued at stimulus, popped at observation.
module tb_pipe_io_timer;
    import pipe_io_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_00c0;

    logic        clock;
    logic        resetn;
    logic        wmem;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        sel;
    logic [31:0] dataout;
    logic        tick_out;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] sb_q[$];

    pipe_io_timer #(
        .BASE_ADDR (BASE),
        .PRESC_W   (16)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .wmem     (wmem),
        .addr     (addr),
        .datain   (datain),
        .sel      (sel),
        .dataout  (dataout),
        .tick_out (tick_out)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = sb_q.pop_front();
        n_chk++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    endtask

    task automatic rd_addr(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_sel, input string tag);
        addr = a;
        sb_q.push_back(exp_d);
        sb_q.push_back(32'(exp_sel));
        #1;
        compare({tag, ".data"}, dataout);
        compare({tag, ".sel"}, 32'(sel));
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp_d, input string tag);
        rd_addr(BASE + (32'(off) << 2), exp_d, 1'b1, tag);
    endtask

    task automatic chk_tick(input logic exp_t, input string tag);
        sb_q.push_back(32'(exp_t));
        #1;
        compare(tag, 32'(tick_out));
    endtask

    // Called at a negedge; the store lands on the following posedge, returns at the next negedge.
    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        wmem   = 1'b1;
        addr   = BASE + (32'(off) << 2);
        datain = d;
        @(negedge clock);
        wmem   = 1'b0;
        datain = '0;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0;
        wmem   = 1'b0;
        addr   = BASE;
        datain = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        step();

        // Reset state and window decode
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, "reset_rd");
        rd_addr(BASE + 32'h20, 32'h0, 1'b0, "out_of_window");
        rd_addr(BASE + 32'h1f, 32'h0, 1'b1, "window_top");
        step();

        // Register widths, read-only and unmapped offsets
        wr(TMR_PRESC, 32'hffff_1234);
        rd(TMR_PRESC, 32'h0000_1234, "presc_zext");
        wr(TMR_CTRL, 32'hffff_fffe);
        rd(TMR_CTRL, 32'h0000_0002, "ctrl_bits");
        wr(TMR_CTRL, 32'h0);
        wr(3'd5, 32'hdead_beef);
        rd(3'd5, 32'h0, "unmapped_wr");
        wr(TMR_COUNT, 32'h7);
        rd(TMR_COUNT, 32'h0, "count_ro");

        // Auto-reload, PRESC=0, LOAD=5
        wr(TMR_PRESC, 32'h0);
        wr(TMR_LOAD, 32'h5);
        wr(TMR_CTRL, 32'h3);
        rd(TMR_COUNT, 32'h5, "rl_count0");
        for (int i = 1; i < 5; i++) begin
            step();
            rd(TMR_COUNT, 32'(5 - i), "rl_count");
            chk_tick(1'b0, "rl_tick_lo");
        end
        step();
        rd(TMR_COUNT, 32'h5, "rl_reloaded");
        rd(TMR_STATUS, 32'h0000_0101, "rl_status1");
        chk_tick(1'b1, "rl_tick_hi1");
        for (int i = 1; i < 5; i++) begin
            step();
            chk_tick(1'b0, "rl_gap");
        end
        step();
        chk_tick(1'b1, "rl_tick_hi2");
        rd(TMR_STATUS, 32'h0000_0201, "rl_status2");
        wr(TMR_CTRL, 32'h0);
        rd(TMR_COUNT, 32'h5, "stop_wins");
        rd(TMR_CTRL, 32'h0, "stop_ctrl");
        chk_tick(1'b0, "stop_tick");
        repeat (3) step();
        rd(TMR_COUNT, 32'h5, "stop_hold");

        // W1C of expired leaves the count
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h0000_0200, "w1c");

        // One-shot, PRESC=3, LOAD=2: expiry 8 cycles after enabling
        wr(TMR_PRESC, 32'h3);
        wr(TMR_LOAD, 32'h2);
        wr(TMR_CTRL, 32'h1);
        rd(TMR_COUNT, 32'h2, "os_count0");
        for (int i = 1; i < 8; i++) begin
            step();
            chk_tick(1'b0, "os_tick_lo");
            rd(TMR_COUNT, (i < 4) ? 32'h2 : 32'h1, "os_count");
        end
        step();
        chk_tick(1'b1, "os_tick_hi");
        rd(TMR_COUNT, 32'h0, "os_count_end");
        rd(TMR_CTRL, 32'h0, "os_ctrl_end");
        rd(TMR_STATUS, 32'h0000_0301, "os_status");
        for (int i = 0; i < 50; i++) begin
            step();
            chk_tick(1'b0, "os_quiet");
        end
        rd(TMR_COUNT, 32'h0, "os_count_idle");

        // W1C landing on the expiry edge: set wins
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h0000_0300, "w1c2");
        wr(TMR_PRESC, 32'h0);
        wr(TMR_LOAD, 32'h3);
        wr(TMR_CTRL, 32'h1);
        step();
        step();
        rd(TMR_COUNT, 32'h1, "race_pre");
        wr(TMR_STATUS, 32'h1);
        rd(TMR_STATUS, 32'h0000_0401, "race_set_wins");
        chk_tick(1'b1, "race_tick");

        // LOAD store on the would-be expiry edge: store wins
        wr(TMR_LOAD, 32'h2);
        wr(TMR_CTRL, 32'h1);
        step();
        rd(TMR_COUNT, 32'h1, "ldw_pre");
        wr(TMR_LOAD, 32'h9);
        rd(TMR_COUNT, 32'h9, "ldw_count");
        chk_tick(1'b0, "ldw_tick");
        rd(TMR_STATUS, 32'h0000_0401, "ldw_status");
        step();
        rd(TMR_COUNT, 32'h8, "ldw_resume");
        chk_tick(1'b0, "ldw_tick2");
        wr(TMR_CTRL, 32'h0);

        // Expiry counter wrap after a fresh reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        rd(TMR_STATUS, 32'h0, "wrap_start");
        wr(TMR_LOAD, 32'h1);
        wr(TMR_CTRL, 32'h3);
        repeat (255) step();
        rd(TMR_STATUS, 32'h0000_ff01, "wrap_255");
        chk_tick(1'b1, "wrap_tick255");
        step();
        rd(TMR_STATUS, 32'h0000_0001, "wrap_0");
        rd(TMR_COUNT, 32'h1, "wrap_count");
        chk_tick(1'b1, "wrap_tick256");

        // Asynchronous reset while running, clock low
        resetn = 1'b0;
        chk_tick(1'b0, "async_tick");
        for (int i = 0; i < 5; i++) rd(3'(i), 32'h0, "async_reg");
        step();
        resetn = 1'b1;
        step();
        rd(TMR_COUNT, 32'h0, "post_rst_count");
        chk_tick(1'b0, "post_rst_tick");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
